// File: rtl/ppt_pkg.sv
// Shared types and default widths for the PPT pulse path.
package ppt_pkg;

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_BURST_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/pulse_generator_if.sv
// Control/config/status bundle between the config path and the pulse generator.
interface pulse_generator_if #(
    parameter int CNT_W   = ppt_pkg::DEF_CNT_W,
    parameter int BURST_W = ppt_pkg::DEF_BURST_W
);
    logic               tick_en;
    logic [CNT_W-1:0]   cfg_high;
    logic [CNT_W-1:0]   cfg_low;
    logic [BURST_W-1:0] cfg_burst;
    logic               start;
    logic               stop;
    logic               pulse_out;
    logic               pulse_edge;
    logic               busy;
    logic               done;

    modport master (
        output tick_en, cfg_high, cfg_low, cfg_burst, start, stop,
        input  pulse_out, pulse_edge, busy, done
    );

    modport slave (
        input  tick_en, cfg_high, cfg_low, cfg_burst, start, stop,
        output pulse_out, pulse_edge, busy, done
    );
endinterface

// File: rtl/pulse_generator_phase_timer.sv
// Loadable down-counter timing one high or low phase; expire fires on the
// enabled tick that ends the phase.
module phase_timer #(
    parameter int CNT_W = ppt_pkg::DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: a reload wins over the decrement of the expiring tick.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en && cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expire = (cnt_q == CNT_W'(1)) && en;
endmodule

// File: rtl/pulse_generator.sv
// Programmable pulse-train generator: finite bursts or continuous trains of
// high/low pulses, timed in tick_en units.
module pulse_generator
    import ppt_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic             clk,
    input  logic             rst,
    pulse_generator_if.slave bus
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   high_q, high_d, low_q, low_d;
    logic [BURST_W-1:0] burst_q, burst_d, pcnt_q, pcnt_d, pcnt_inc;
    logic               pulse_out_q, pulse_out_d, pulse_edge_q, pulse_edge_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               tmr_load, tmr_en, tmr_expire;
    logic [CNT_W-1:0]   tmr_val;

    // A zero-length phase still lasts one tick.
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    assign pcnt_inc = pcnt_q + BURST_W'(1);

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    // Next-state, config latch, burst count and timer control.
    always_comb begin
        state_d  = state_q;
        high_d   = high_q;
        low_d    = low_q;
        burst_d  = burst_q;
        pcnt_d   = pcnt_q;
        tmr_load = 1'b0;
        tmr_val  = at_least_one(high_q);
        tmr_en   = bus.tick_en && (state_q == ST_HIGH || state_q == ST_LOW);

        if (bus.stop) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (bus.start) begin
                    high_d   = bus.cfg_high;
                    low_d    = bus.cfg_low;
                    burst_d  = bus.cfg_burst;
                    pcnt_d   = '0;
                    tmr_load = 1'b1;
                    tmr_val  = at_least_one(bus.cfg_high);
                    state_d  = ST_HIGH;
                end
                ST_HIGH: if (tmr_expire) begin
                    tmr_load = 1'b1;
                    tmr_val  = at_least_one(low_q);
                    state_d  = ST_LOW;
                end
                ST_LOW: if (tmr_expire) begin
                    pcnt_d = pcnt_inc;
                    // Continuous mode (burst 0) never matches, so wrap is harmless.
                    if (burst_q != '0 && pcnt_inc == burst_q) begin
                        state_d = ST_DONE;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = at_least_one(high_q);
                        state_d  = ST_HIGH;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        // Outputs are registered copies of where the FSM is heading.
        pulse_out_d  = (state_d == ST_HIGH);
        pulse_edge_d = (state_d == ST_HIGH) && (state_q != ST_HIGH);
        busy_d       = (state_d == ST_HIGH) || (state_d == ST_LOW);
        done_d       = (state_d == ST_DONE);
    end

    // State, latched config and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            high_q       <= '0;
            low_q        <= '0;
            burst_q      <= '0;
            pcnt_q       <= '0;
            pulse_out_q  <= 1'b0;
            pulse_edge_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            high_q       <= high_d;
            low_q        <= low_d;
            burst_q      <= burst_d;
            pcnt_q       <= pcnt_d;
            pulse_out_q  <= pulse_out_d;
            pulse_edge_q <= pulse_edge_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.pulse_out  = pulse_out_q;
    assign bus.pulse_edge = pulse_edge_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_pulse_generator.sv
// Randomized bench for pulse_generator against a phase-queue reference model.
module tb_pulse_generator;
    localparam int CW = 8;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pulse_generator_if #(.CNT_W(CW), .BURST_W(BW)) bus ();

    pulse_generator #(.CNT_W(CW), .BURST_W(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: on start, the whole burst is laid out as a queue of phases
    // (level, ticks). Ticks drain the head phase; popping into a high phase
    // is a rising edge; an empty queue means the burst is finished.
    typedef struct {
        bit lvl;
        int t;
    } ph_t;

    ph_t q[$];
    int  mode;      // 0 idle, 1 running, 2 done strobe
    int  lh, ll;
    bit  cont;
    bit  e_out, e_edge, e_busy, e_done;
    int  n_chk, n_pass;
    int  cyc_n, tick_per;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc_n, got, exp);
    endtask

    task automatic push_pair();
        q.push_back('{lvl: 1'b1, t: lh});
        q.push_back('{lvl: 1'b0, t: ll});
    endtask

    task automatic model_step(input bit st, input bit sp, input bit tk, input bit r);
        e_edge = 1'b0;
        if (r || sp) begin
            mode = 0;
            q.delete();
        end else begin
            case (mode)
                0: if (st) begin
                    lh   = (bus.cfg_high == 0) ? 1 : int'(bus.cfg_high);
                    ll   = (bus.cfg_low  == 0) ? 1 : int'(bus.cfg_low);
                    cont = (bus.cfg_burst == 0);
                    q.delete();
                    if (cont) push_pair();
                    else for (int i = 0; i < int'(bus.cfg_burst); i++) push_pair();
                    mode   = 1;
                    e_edge = 1'b1;
                end
                1: if (tk) begin
                    q[0].t--;
                    if (q[0].t == 0) begin
                        void'(q.pop_front());
                        if (cont && q.size() < 2) push_pair();
                        if (q.size() == 0) mode = 2;
                        else if (q[0].lvl) e_edge = 1'b1;
                    end
                end
                default: mode = 0;
            endcase
        end
        e_out  = (mode == 1) && q[0].lvl;
        e_busy = (mode == 1);
        e_done = (mode == 2);
    endtask

    task automatic cyc(input bit st, input bit sp, input bit r);
        rst       = r;
        bus.start = st;
        bus.stop  = sp;
        bus.tick_en = (tick_per == 0) ? 1'($urandom_range(0, 1)) : ((cyc_n % tick_per) == 0);
        model_step(st, sp, bus.tick_en, r);
        @(posedge clk);
        #1;
        cyc_n++;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("pulse_out",  bus.pulse_out,  e_out);
        chk("pulse_edge", bus.pulse_edge, e_edge);
        chk("busy",       bus.busy,       e_busy);
        chk("done",       bus.done,       e_done);
    endtask

    task automatic set_cfg(input int h, input int l, input int b);
        bus.cfg_high  = CW'(h);
        bus.cfg_low   = CW'(l);
        bus.cfg_burst = BW'(b);
    endtask

    int t1_po  [12] = '{1,1,1,0,0,1,1,1,0,0,0,0};
    int t1_edge[12] = '{1,0,0,0,0,1,0,0,0,0,0,0};
    int t1_done[12] = '{0,0,0,0,0,0,0,0,0,0,1,0};
    int n_done;

    initial begin
        n_chk = 0; n_pass = 0; cyc_n = 0; tick_per = 1; mode = 0;
        bus.tick_en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        set_cfg(0, 0, 0);

        // Reset state
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out",  bus.pulse_out, 0);

        // 1: high=3 low=2 burst=2, absolute timeline from start at cycle 0
        set_cfg(3, 2, 2);
        cyc(1, 0, 0);
        chk("t1_po_c1", bus.pulse_out, 1);
        for (int i = 1; i < 12; i++) begin
            cyc(0, 0, 0);
            chk("t1_po",   bus.pulse_out,  t1_po[i]);
            chk("t1_edge", bus.pulse_edge, t1_edge[i]);
            chk("t1_done", bus.done,       t1_done[i]);
        end

        // 2: zero widths act as one tick
        set_cfg(0, 0, 3);
        cyc(1, 0, 0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0);
            if (bus.done) n_done++;
        end
        chk("t2_done_cnt", n_done, 1);

        // 3: sparse ticks stretch phases
        tick_per = 4;
        set_cfg(2, 1, 1);
        cyc(1, 0, 0);
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0);
            if (bus.done) n_done++;
        end
        chk("t3_done_cnt", n_done, 1);
        tick_per = 1;

        // 4: continuous, 600+ pulses, pulse count wraps, then stop
        set_cfg(1, 1, 0);
        cyc(1, 0, 0);
        n_done = 0;
        for (int i = 0; i < 1205; i++) begin
            cyc(0, 0, 0);
            if (bus.done) n_done++;
        end
        cyc(0, 1, 0);
        chk("t4_stop_busy", bus.busy, 0);
        chk("t4_stop_out",  bus.pulse_out, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        chk("t4_no_done", n_done, 0);

        // 5: collisions
        set_cfg(4, 3, 2);
        cyc(1, 1, 0);
        chk("t5_start_stop", bus.busy, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        bus.cfg_high = 8'd9;
        bus.cfg_low  = 8'd7;
        for (int i = 0; i < 16; i++) cyc(0, 0, 0);

        // 6: reset during LOW, then a fresh full burst
        set_cfg(2, 3, 5);
        cyc(1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        chk("t6_in_low", bus.busy, 1);
        cyc(0, 0, 1);
        chk("t6_rst_busy", bus.busy, 0);
        cyc(1, 0, 0);
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(0, 0, 0);
            if (bus.done) n_done++;
        end
        chk("t6_done_cnt", n_done, 1);

        // Random traffic
        for (int tr = 0; tr < 25; tr++) begin
            tick_per = $urandom_range(0, 3);
            for (int i = 0; i < 60; i++) begin
                set_cfg($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 4));
                cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 199) == 0));
            end
            cyc(0, 1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
